// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and default widths for the ADC front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_pkg;

  localparam int ADC_W_DATA = 18;
  localparam int ADC_W_CHAN = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONVST    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_READ      = 2'd3
  } state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: SCLK divider with one-cycle rise/fall strobes, idles high.
// Latency: first falling edge SCLK_DIV cycles after enable; strobes coincide with the new SCLK level.
// Backpressure: none; dropping en_in forces SCLK high and restarts the phase.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en_in,
  output logic sclk_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next-state: count half-period, toggle SCLK and flag the direction of the edge.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!en_in) begin
      div_d  = '0;
      sclk_d = 1'b1;
    end else if (div_q == DW'(SCLK_DIV - 1)) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      rise_d = ~sclk_q;
      fall_d = sclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider registers; strobes are registered so they line up with sclk_out.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sclk_out = sclk_q;
  assign rise_out = rise_q;
  assign fall_out = fall_q;

endmodule

// File: rtl/adc_controller.sv
// adc_controller: CONVST -> wait BUSY -> serial read of N_CHAN words; optional ADC_TEST_PATTERN_EN.
// Latency: data_valid_out one cycle after the final SCLK-rise sample of each word.
// Backpressure: none; consumers must accept strobes as they come (no stalling).
module adc_controller
  import adc_pkg::*;
#(
  parameter int W_DATA       = ADC_W_DATA,
  parameter int N_CHAN       = 8,
  parameter int W_CHAN       = ADC_W_CHAN,
  parameter int SCLK_DIV     = 2,
  parameter int CONVST_CYC   = 4,
  parameter int BUSY_TIMEOUT = 1000
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     cstart_in,
  input  logic                     busy_in,
  input  logic                     dout_in,
  output logic                     convst_out,
  output logic                     cs_n_out,
  output logic                     sclk_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic        [W_CHAN-1:0] chan_out,
  output logic                     data_valid_out,
  output logic                     cycle_done_out,
  output logic                     timeout_out
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > CONVST_CYC) ? BUSY_TIMEOUT : CONVST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(W_DATA);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_s1_q, busy_s2_q, busy_s3_q;
  logic                seen_rise_q, seen_rise_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [W_CHAN-1:0]   chan_cnt_q, chan_cnt_d;
  logic [W_DATA-1:0]   shift_q, shift_d;
  logic [W_DATA-1:0]   data_q, data_d;
  logic [W_CHAN-1:0]   chan_q, chan_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;
  logic                sclk_en, sclk_rise, sclk_fall;
  logic                serial_bit;
  logic                busy_rise, busy_fall;

  assign busy_rise = busy_s2_q & ~busy_s3_q;
  assign busy_fall = ~busy_s2_q & busy_s3_q;

  // SCLK runs only while staying in READ, so it is already high in the cycle that leaves READ.
  assign sclk_en = (state_q == ST_READ) && (state_d == ST_READ);

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en_in    (sclk_en),
    .sclk_out (sclk_out),
    .rise_out (sclk_rise),
    .fall_out (sclk_fall)
  );

`ifdef ADC_TEST_PATTERN_EN
  logic [W_DATA-W_CHAN-1:0] tp_cnt_q;
  logic [W_DATA-1:0]        tp_sr_q;
  logic                     unused_tp;

  // Synthetic serial source: load {chan, cycle count} on a word's first SCLK fall, shift on later falls.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      tp_cnt_q <= '0;
      tp_sr_q  <= '0;
    end else begin
      if (done_q) tp_cnt_q <= tp_cnt_q + 1'b1;
      if (state_q != ST_READ) tp_sr_q <= '0;
      else if (sclk_fall) begin
        if (bit_q == '0) tp_sr_q <= {chan_cnt_q, tp_cnt_q};
        else             tp_sr_q <= tp_sr_q << 1;
      end
    end
  end

  assign serial_bit = tp_sr_q[W_DATA-1];
  assign unused_tp  = dout_in;
`else
  logic unused_fall;
  assign serial_bit  = dout_in;
  assign unused_fall = sclk_fall;
`endif

  // Two-flop synchroniser plus one delay stage for BUSY edge detection.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      busy_s3_q <= 1'b0;
    end else begin
      busy_s1_q <= busy_in;
      busy_s2_q <= busy_s1_q;
      busy_s3_q <= busy_s2_q;
    end
  end

  // Next-state, counters, shift register and output strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_rise_d = seen_rise_q;
    bit_d       = bit_q;
    chan_cnt_d  = chan_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    chan_d      = chan_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        seen_rise_d = 1'b0;
        bit_d       = '0;
        chan_cnt_d  = '0;
        if (cstart_in) state_d = ST_CONVST;
      end
      ST_CONVST: begin
        if (cnt_q == CNT_W'(CONVST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (busy_rise) seen_rise_d = 1'b1;
        // A fall only counts once a rise has been seen in this wait.
        if (seen_rise_q && busy_fall) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (sclk_rise) begin
          shift_d = {shift_q[W_DATA-2:0], serial_bit};
          if (bit_q == BIT_W'(W_DATA - 1)) begin
            bit_d   = '0;
            data_d  = shift_d;
            chan_d  = chan_cnt_q;
            valid_d = 1'b1;
            if (chan_cnt_q == W_CHAN'(N_CHAN - 1)) begin
              done_d     = 1'b1;
              chan_cnt_d = '0;
              state_d    = ST_IDLE;
            end else begin
              chan_cnt_d = chan_cnt_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seen_rise_q <= 1'b0;
      bit_q       <= '0;
      chan_cnt_q  <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_rise_q <= seen_rise_d;
      bit_q       <= bit_d;
      chan_cnt_q  <= chan_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
    end
  end

  assign convst_out     = (state_q != ST_CONVST);
  assign cs_n_out       = (state_q != ST_READ);
  assign data_out       = data_q;
  assign chan_out       = chan_q;
  assign data_valid_out = valid_q;
  assign cycle_done_out = done_q;
  assign timeout_out    = tmo_q;

endmodule

// File: tb/tb_adc_controller.sv
// tb_adc_controller: directed bench with a behavioural serial ADC and strobe monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_controller;

  logic               clk_in = 1'b0;
  logic               reset_in = 1'b1;
  logic               cstart_in = 1'b0;
  logic               busy_in = 1'b0;
  logic               dout_in = 1'b0;
  logic               convst_out, cs_n_out, sclk_out;
  logic signed [17:0] data_out;
  logic [2:0]         chan_out;
  logic               data_valid_out, cycle_done_out, timeout_out;

  adc_controller dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .cstart_in      (cstart_in),
    .busy_in        (busy_in),
    .dout_in        (dout_in),
    .convst_out     (convst_out),
    .cs_n_out       (cs_n_out),
    .sclk_out       (sclk_out),
    .data_out       (data_out),
    .chan_out       (chan_out),
    .data_valid_out (data_valid_out),
    .cycle_done_out (cycle_done_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural ADC ----------------
  logic [17:0] adc_word [8];
  int          m_ch = 0;
  int          m_bit = 0;
  bit          busy_en = 1'b1;

  always @(negedge cs_n_out) begin
    m_ch  = 0;
    m_bit = 0;
  end

  // Present the next bit on each SCLK fall; the controller samples it on the following rise.
  always @(negedge sclk_out) begin
    if (cs_n_out === 1'b0 && m_ch < 8) begin
      dout_in = adc_word[m_ch][17-m_bit];
      m_bit++;
      if (m_bit == 18) begin
        m_bit = 0;
        m_ch++;
      end
    end
  end

  always @(posedge convst_out) begin
    if (busy_en) begin
      repeat (3) @(posedge clk_in);
      busy_in = 1'b1;
      repeat (20) @(posedge clk_in);
      busy_in = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic signed [17:0] v_data[$];
  logic [2:0]         v_chan[$];
  int                 v_cyc[$];
  logic               v_done[$];
  int                 d_cyc[$], t_cyc[$], f_cyc[$], r_cyc[$];
  int                 cs_low = 0;
  logic               prev_convst = 1'b1;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) begin
      v_data.push_back(data_out);
      v_chan.push_back(chan_out);
      v_cyc.push_back(cyc);
      v_done.push_back(cycle_done_out);
    end
    if (cycle_done_out === 1'b1) d_cyc.push_back(cyc);
    if (timeout_out === 1'b1) t_cyc.push_back(cyc);
    if (prev_convst === 1'b1 && convst_out === 1'b0) f_cyc.push_back(cyc);
    if (prev_convst === 1'b0 && convst_out === 1'b1) r_cyc.push_back(cyc);
    if (cs_n_out === 1'b0) cs_low++;
    prev_convst = convst_out;
  end

  task automatic clear_mon();
    v_data.delete(); v_chan.delete(); v_cyc.delete(); v_done.delete();
    d_cyc.delete(); t_cyc.delete(); f_cyc.delete(); r_cyc.delete();
    cs_low = 0;
  endtask

  function automatic int qsz(input int which);
    case (which)
      0:       return d_cyc.size();
      1:       return t_cyc.size();
      default: return v_data.size();
    endcase
  endfunction

  // Bounded wait: which 0=done strobes, 1=timeouts, 2=data strobes.
  task automatic wait_for(input string name, input int which, input int n, input int budget);
    int i = 0;
    while (qsz(which) < n && i < budget) begin
      @(negedge clk_in);
      #1;
      i++;
    end
    check(name, qsz(which) >= n, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk_in); #1 cstart_in = 1'b1;
    @(posedge clk_in); #1 cstart_in = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [17:0]        word;
    logic signed [17:0] exp_data;
    logic [2:0]         exp_chan;
    logic               exp_done;
  } vec_t;

  vec_t tv [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int errs;

    for (int k = 0; k < 8; k++) begin
      tv[k].word     = 18'h00100 + 18'(k);
      tv[k].exp_data = 18'sd256 + 18'(k);
      tv[k].exp_chan = 3'(k);
      tv[k].exp_done = (k == 7);
    end
    tv[8].word  = 18'h1FFFF; tv[8].exp_data  = 131071;
    tv[9].word  = 18'h00000; tv[9].exp_data  = 0;
    tv[10].word = 18'h3FFFF; tv[10].exp_data = -1;
    tv[11].word = 18'h2AAAA; tv[11].exp_data = -87382;
    tv[12].word = 18'h15555; tv[12].exp_data = 87381;
    tv[13].word = 18'h20000; tv[13].exp_data = -131072;
    tv[14].word = 18'h00001; tv[14].exp_data = 1;
    tv[15].word = 18'h3FFFE; tv[15].exp_data = -2;
    for (int k = 8; k < 16; k++) begin
      tv[k].exp_chan = 3'(k - 8);
      tv[k].exp_done = (k == 15);
    end

    // 1: reset values, then 100 idle cycles with cstart low.
    repeat (3) @(posedge clk_in);
    #1;
    check("rst convst", convst_out, 1);
    check("rst cs_n", cs_n_out, 1);
    check("rst sclk", sclk_out, 1);
    check("rst data", data_out, 0);
    check("rst chan", chan_out, 0);
    check("rst valid", data_valid_out, 0);
    check("rst done", cycle_done_out, 0);
    check("rst timeout", timeout_out, 0);
    reset_in = 1'b0;
    clear_mon();
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (convst_out !== 1'b1 || cs_n_out !== 1'b1 || sclk_out !== 1'b1 ||
          data_valid_out !== 1'b0 || cycle_done_out !== 1'b0 || timeout_out !== 1'b0)
        viol++;
    end
    check("idle 100 cycles", viol, 0);

    // 2 and 3: one single-shot conversion per table group.
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 8; k++) adc_word[k] = tv[g*8+k].word;
      clear_mon();
      pulse_start();
      wait_for("conv done", 0, 1, 2000);
      repeat (5) @(negedge clk_in);
      check("strobe count", v_data.size(), 8);
      check("done count", d_cyc.size(), 1);
      if (f_cyc.size() > 0 && r_cyc.size() > 0)
        check("convst low cycles", r_cyc[0] - f_cyc[0], 4);
      else
        check("convst pulse seen", 0, 1);
      for (int k = 0; k < 8; k++) begin
        if (k < v_data.size()) begin
          check($sformatf("g%0d ch%0d data", g, k), v_data[k], tv[g*8+k].exp_data);
          check($sformatf("g%0d ch%0d chan", g, k), v_chan[k], tv[g*8+k].exp_chan);
          check($sformatf("g%0d ch%0d done", g, k), v_done[k], tv[g*8+k].exp_done);
          if (k > 0) check($sformatf("g%0d ch%0d spacing", g, k), v_cyc[k] - v_cyc[k-1], 72);
        end else begin
          check($sformatf("g%0d ch%0d present", g, k), 0, 1);
        end
      end
    end

    // 4: BUSY never moves -> timeout 1000 cycles after entering WAIT_BUSY.
    busy_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_for("timeout seen", 1, 1, 1500);
    repeat (20) @(negedge clk_in);
    if (t_cyc.size() > 0 && r_cyc.size() > 0)
      check("timeout delay", t_cyc[0] - r_cyc[0], 1000);
    else
      check("timeout delay present", 0, 1);
    check("timeout count", t_cyc.size(), 1);
    check("timeout no data", v_data.size(), 0);
    check("timeout cs_n stayed high", cs_low, 0);
    busy_en = 1'b1;

    // 5: reset 10 cycles after the chan 3 strobe aborts the read.
    clear_mon();
    pulse_start();
    wait_for("chan3 strobe", 2, 4, 2000);
    repeat (10) @(posedge clk_in);
    #1 reset_in = 1'b1;
    @(posedge clk_in); #1;
    check("abort cs_n", cs_n_out, 1);
    check("abort sclk", sclk_out, 1);
    check("abort data", data_out, 0);
    check("abort chan", chan_out, 0);
    @(posedge clk_in); #1 reset_in = 1'b0;
    repeat (700) @(negedge clk_in);
    check("abort no more strobes", v_data.size(), 4);
    check("abort no done", d_cyc.size(), 0);

    // 6: cstart held for three back-to-back conversions.
    clear_mon();
    @(posedge clk_in); #1 cstart_in = 1'b1;
    wait_for("three conversions", 0, 3, 3000);
    cstart_in = 1'b0;
    repeat (100) @(negedge clk_in);
    check("cont strobe count", v_data.size(), 24);
    check("cont convst count", f_cyc.size(), 3);
    errs = 0;
    for (int i = 0; i < v_data.size(); i++) begin
      if (v_chan[i] !== tv[8 + (i % 8)].exp_chan) errs++;
      if (v_data[i] !== tv[8 + (i % 8)].exp_data) errs++;
    end
    check("cont data/chan errors", errs, 0);
    if (f_cyc.size() >= 3 && d_cyc.size() >= 2) begin
      check("cont restart 1", f_cyc[1], d_cyc[0] + 1);
      check("cont restart 2", f_cyc[2], d_cyc[1] + 1);
    end else begin
      check("cont restarts present", 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
